// File: rtl/upc_marquee_pkg.sv
// Shared types, name ROM and segment font for the product-code marquee.
// Glyphs are active-low, bit order gfedcba.
package upc_pkg;

   typedef enum logic [4:0] {
      CH_BLANK, CH_A, CH_B, CH_C, CH_E, CH_H, CH_I, CH_J, CH_K, CH_L,
      CH_M, CH_N, CH_O, CH_R, CH_S, CH_T, CH_U, CH_W, CH_Y
   } char_t;

   typedef enum logic [1:0] {S_IDLE, S_SCROLL, S_ERROR} state_t;

   localparam int NAME_W = 8;

   // Indexed by code {U,P,C}; the two invalid codes hold blank rows.
   localparam char_t NAMES [8][NAME_W] = '{
      '{CH_S, CH_H, CH_O, CH_E, CH_S, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_J, CH_E, CH_W, CH_E, CH_L, CH_R, CH_Y, CH_BLANK},
      '{CH_O, CH_R, CH_N, CH_A, CH_M, CH_E, CH_N, CH_T},
      '{CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_B, CH_U, CH_S, CH_I, CH_N, CH_E, CH_S, CH_S},
      '{CH_W, CH_E, CH_T, CH_S, CH_U, CH_I, CH_T, CH_BLANK},
      '{CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_S, CH_O, CH_C, CH_K, CH_S, CH_BLANK, CH_BLANK, CH_BLANK}
   };

   function automatic logic [6:0] glyph(char_t c);
      case (c)
         CH_A:    return 7'b0001000;
         CH_B:    return 7'b0000011;
         CH_C:    return 7'b1000110;
         CH_E:    return 7'b0000110;
         CH_H:    return 7'b0001001;
         CH_I:    return 7'b1001111;
         CH_J:    return 7'b1100001;
         CH_K:    return 7'b0001010;
         CH_L:    return 7'b1000111;
         CH_M:    return 7'b1001000;
         CH_N:    return 7'b0101011;
         CH_O:    return 7'b1000000;
         CH_R:    return 7'b0101111;
         CH_S:    return 7'b0010010;
         CH_T:    return 7'b0000111;
         CH_U:    return 7'b1000001;
         CH_W:    return 7'b1010101;
         CH_Y:    return 7'b0010001;
         default: return 7'h7F;
      endcase
   endfunction

   // "ERROR" right-justified: digit 0 is the final R.
   function automatic char_t err_char(int k);
      case (k)
         0:       return CH_R;
         1:       return CH_O;
         2:       return CH_R;
         3:       return CH_R;
         4:       return CH_E;
         default: return CH_BLANK;
      endcase
   endfunction

   function automatic logic code_bad(logic [2:0] c);
      return (c == 3'b011) || (c == 3'b110);
   endfunction

   function automatic logic discount_of(logic [2:0] c);
      return c[1] | (c[2] & c[0]);
   endfunction

   function automatic logic stolen_of(logic [2:0] c, logic m);
      return ~m & ~c[1] & (c[2] | ~c[0]);
   endfunction

endpackage

// File: rtl/upc_marquee_seg_glyph.sv
// One seven-segment digit decoder; pure combinational font lookup.
module seg_glyph
   import upc_pkg::*;
(
   input  char_t      ch,
   output logic [6:0] seg
);
   assign seg = glyph(ch);
endmodule

// File: rtl/upc_marquee.sv
// Product-code marquee: latches a code on load, scrolls its name right-to-left
// across NUM_DIGITS digits, and decodes discount/stolen flags.
module upc_marquee
   import upc_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int MSG_LEN    = 8,
   parameter int TICK_DIV   = 25_000_000
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [2:0]                 code,
   input  logic                       mark,
   input  logic                       load,
   input  logic                       hold,
   output logic [NUM_DIGITS-1:0][6:0] hex,
   output logic                       discount,
   output logic                       stolen,
   output logic                       busy
);
   localparam int L  = NUM_DIGITS + MSG_LEN;
   localparam int FW = (L > 1) ? $clog2(L) : 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t          state;
   logic [2:0]      code_q;
   logic            mark_q;
   logic [FW-1:0]   frame;
   logic [TW-1:0]   tick;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= S_IDLE;
         code_q <= '0;
         mark_q <= 1'b0;
         frame  <= '0;
         tick   <= '0;
      end else if (load) begin
         // Load wins over a coincident tick, so the new code always starts at frame 0.
         code_q <= code;
         mark_q <= mark;
         frame  <= '0;
         tick   <= '0;
         state  <= code_bad(code) ? S_ERROR : S_SCROLL;
      end else if (state == S_SCROLL && !hold) begin
         if (tick == TW'(TICK_DIV - 1)) begin
            tick  <= '0;
            frame <= (frame == FW'(L - 1)) ? '0 : frame + 1'b1;
         end else begin
            tick <= tick + 1'b1;
         end
      end
   end

   assign busy     = (state == S_SCROLL);
   assign discount = busy & discount_of(code_q);
   assign stolen   = busy & stolen_of(code_q, mark_q);

   // Tape = NUM_DIGITS blanks then the padded name; digit k shows tape[(frame+ND-1-k) mod L].
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
      localparam int OFS = NUM_DIGITS - 1 - k;
      char_t ch;
      int    p;
      int    ti;

      always_comb begin
         p  = int'(frame) + OFS;
         if (p >= L) p = p - L;
         ti = p - NUM_DIGITS;
         ch = CH_BLANK;
         if (state == S_ERROR)
            ch = err_char(k);
         else if (state == S_SCROLL && ti >= 0 && ti < NAME_W && ti < MSG_LEN)
            ch = NAMES[code_q][ti[2:0]];
      end

      seg_glyph u_seg (.ch(ch), .seg(hex[k]));
   end

endmodule
